// File: rtl/usdr_pkg.sv
// rtl/usdr_pkg.sv - shared types and constants for the serial deserializer path
//
// Purpose: FSM state type, bit-order encoding shared with the shift register's
//          serial-out side, and the bit-counter width helper.
// Ports:   none (package).
package usdr_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit-order encoding: which end of the word the first serial bit belongs to.
  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

  // Counter must represent 0..width inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_deserializer_if.sv
// rtl/serial_deserializer_if.sv - serial-in / parallel-out handshake bundle
//
// Purpose: groups the serial input strobe, parallel valid/ready output and
//          status flags of the deserializer.
// Ports (signals):
//   s_in, s_valid, s_frame : serial bit, bit strobe, start-of-word marker
//   p_data, p_valid, p_ready : assembled word with valid/ready handshake
//   overrun, frame_err     : one-cycle status pulses
//   busy                   : word assembly in progress
// Modports: master = stimulus/consumer side, slave = deserializer side.
interface serial_deserializer_if #(
  parameter int WIDTH = 4
);

  logic             s_in;
  logic             s_valid;
  logic             s_frame;
  logic [WIDTH-1:0] p_data;
  logic             p_valid;
  logic             p_ready;
  logic             overrun;
  logic             frame_err;
  logic             busy;

  modport master (
    output s_in, s_valid, s_frame, p_ready,
    input  p_data, p_valid, overrun, frame_err, busy
  );

  modport slave (
    input  s_in, s_valid, s_frame, p_ready,
    output p_data, p_valid, overrun, frame_err, busy
  );

endinterface

// File: rtl/deser_shift_core.sv
// rtl/deser_shift_core.sv - bit counter and shift register for word assembly
//
// Purpose: accumulates serial bits into a WIDTH-bit word and signals the
//          strobe that completes it.
// Ports:
//   i_clk    : clock, rising edge
//   clr      : synchronous active-high reset
//   shift_en : append s_in to the partial word
//   restart  : drop the partial word, s_in becomes bit 0 of a new word
//   s_in     : serial data bit
//   word     : completed word, valid in the cycle done is high
//   done     : high in the cycle whose strobe completes the word
module deser_shift_core import usdr_pkg::*; #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic             i_clk,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             restart,
  input  logic             s_in,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int             CW   = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;

  // MSB-first shifts left so the first bit ends in the top position;
  // LSB-first shifts right so the first bit ends in position 0.
  if (MSB_FIRST == MSB_FIRST_ORDER) begin : g_msb
    assign shifted   = {shift_reg[WIDTH-2:0], s_in};
    assign first_bit = {{(WIDTH-1){1'b0}}, s_in};
  end else begin : g_lsb
    assign shifted   = {s_in, shift_reg[WIDTH-1:1]};
    assign first_bit = {s_in, {(WIDTH-1){1'b0}}};
  end

  // The completing bit never sits in shift_reg; the word is formed on the fly.
  assign word = shifted;
  assign done = shift_en && (count == LAST);

  always_ff @(posedge i_clk) begin
    if (clr) begin
      count     <= '0;
      shift_reg <= '0;
    end else if (restart) begin
      count     <= CW'(1);
      shift_reg <= first_bit;
    end else if (done) begin
      count     <= '0;
      shift_reg <= '0;
    end else if (shift_en) begin
      count     <= count + CW'(1);
      shift_reg <= shifted;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - framed serial stream to WIDTH-bit word receiver
//
// Purpose: frames serial bits into words, holds each finished word in a
//          one-deep valid/ready register, flags dropped words and re-framing.
// Ports:
//   i_clk : clock, rising edge
//   clr   : synchronous active-high reset
//   bus   : serial_deserializer_if.slave (s_in/s_valid/s_frame in,
//           p_data/p_valid out with p_ready in, overrun/frame_err/busy out)
module serial_deserializer import usdr_pkg::*; #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input  logic                  i_clk,
  input  logic                  clr,
  serial_deserializer_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic             shift_en;
  logic             restart;
  logic             frame_err_d;
  logic             done;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] p_data_q;
  logic             p_valid_q;
  logic             overrun_q;
  logic             frame_err_q;

  deser_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .i_clk    (i_clk),
    .clr      (clr),
    .shift_en (shift_en),
    .restart  (restart),
    .s_in     (bus.s_in),
    .word     (word),
    .done     (done)
  );

  always_ff @(posedge i_clk) begin
    if (clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_en    = 1'b0;
    restart     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Unframed strobes while idle are discarded.
        if (bus.s_valid && bus.s_frame) begin
          restart = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.s_valid && bus.s_frame) begin
          restart     = 1'b1;
          frame_err_d = 1'b1;
        end else if (bus.s_valid) begin
          shift_en = 1'b1;
          if (done) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completing word is accepted when the register is empty or being drained
  // in the same cycle; otherwise it is dropped and the held word is untouched.
  always_ff @(posedge i_clk) begin
    if (clr) begin
      p_data_q    <= '0;
      p_valid_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= 1'b0;
      frame_err_q <= frame_err_d;
      if (done) begin
        if (!p_valid_q || bus.p_ready) begin
          p_data_q  <= word;
          p_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (p_valid_q && bus.p_ready) begin
        p_valid_q <= 1'b0;
      end
    end
  end

  assign bus.p_data    = p_data_q;
  assign bus.p_valid   = p_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - self-checking bench for serial_deserializer
module tb_serial_deserializer;

  localparam int W = 4;

  logic i_clk;
  logic clr;
  int   checks;
  int   errors;

  serial_deserializer_if #(.WIDTH(W)) bus_m ();
  serial_deserializer_if #(.WIDTH(W)) bus_l ();

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .i_clk (i_clk),
    .clr   (clr),
    .bus   (bus_m.slave)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .i_clk (i_clk),
    .clr   (clr),
    .bus   (bus_l.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: bits in arrival order, packed per bit-order at completion.
  bit         q[$];
  bit         in_word;
  logic [W-1:0] e_pd_m;
  logic [W-1:0] e_pd_l;
  bit         e_pv;
  bit         e_ovr;
  bit         e_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit c, input bit v, input bit f, input bit d, input bit r);
    bit           done_w;
    logic [W-1:0] wm;
    logic [W-1:0] wl;
    done_w = 1'b0;
    wm     = '0;
    wl     = '0;
    e_ovr  = 1'b0;
    e_ferr = 1'b0;
    if (c) begin
      q.delete();
      in_word = 1'b0;
      e_pd_m  = '0;
      e_pd_l  = '0;
      e_pv    = 1'b0;
    end else begin
      if (v) begin
        if (f) begin
          if (in_word) e_ferr = 1'b1;
          q.delete();
          q.push_back(d);
          in_word = 1'b1;
        end else if (in_word) begin
          q.push_back(d);
        end
        if (in_word && q.size() == W) begin
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = q[i];
            wl[i]     = q[i];
          end
          done_w  = 1'b1;
          q.delete();
          in_word = 1'b0;
        end
      end
      if (done_w) begin
        if (!e_pv || r) begin
          e_pd_m = wm;
          e_pd_l = wl;
          e_pv   = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (e_pv && r) begin
        e_pv = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("p_data_msb",    32'(bus_m.p_data),    32'(e_pd_m));
    chk("p_data_lsb",    32'(bus_l.p_data),    32'(e_pd_l));
    chk("p_valid_msb",   32'(bus_m.p_valid),   32'(e_pv));
    chk("p_valid_lsb",   32'(bus_l.p_valid),   32'(e_pv));
    chk("overrun_msb",   32'(bus_m.overrun),   32'(e_ovr));
    chk("overrun_lsb",   32'(bus_l.overrun),   32'(e_ovr));
    chk("frame_err_msb", 32'(bus_m.frame_err), 32'(e_ferr));
    chk("frame_err_lsb", 32'(bus_l.frame_err), 32'(e_ferr));
    chk("busy_msb",      32'(bus_m.busy),      32'(in_word));
    chk("busy_lsb",      32'(bus_l.busy),      32'(in_word));
  endtask

  task automatic step(input bit c, input bit v, input bit f, input bit d, input bit r);
    clr           = c;
    bus_m.s_valid = v;
    bus_l.s_valid = v;
    bus_m.s_frame = f;
    bus_l.s_frame = f;
    bus_m.s_in    = d;
    bus_l.s_in    = d;
    bus_m.p_ready = r;
    bus_l.p_ready = r;
    model_update(c, v, f, d, r);
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  // Sends w[W-1] first, framed, on consecutive strobes.
  task automatic send_word(input logic [W-1:0] w, input bit r);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, (i == W - 1), w[i], r);
    end
  endtask

  initial begin
    logic [W-1:0] gap_bits;
    checks  = 0;
    errors  = 0;
    in_word = 1'b0;
    e_pd_m  = '0;
    e_pd_l  = '0;
    e_pv    = 1'b0;
    e_ovr   = 1'b0;
    e_ferr  = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_p_data",    32'(bus_m.p_data),    32'h0);
    chk("rst_p_valid",   32'(bus_m.p_valid),   32'h0);
    chk("rst_busy",      32'(bus_m.busy),      32'h0);
    chk("rst_overrun",   32'(bus_m.overrun),   32'h0);
    chk("rst_frame_err", 32'(bus_m.frame_err), 32'h0);

    // Basic word 1,0,1,1
    send_word(4'b1011, 1'b1);
    chk("basic_p_data_msb", 32'(bus_m.p_data),  32'hB);
    chk("basic_p_data_lsb", 32'(bus_l.p_data),  32'hD);
    chk("basic_p_valid",    32'(bus_m.p_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("basic_p_valid_drop", 32'(bus_m.p_valid), 32'h0);

    // Gapped strobes 0,1,1,0
    gap_bits = 4'b0110;
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, (i == W - 1), gap_bits[i], 1'b1);
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          chk("gap_busy", 32'(bus_l.busy), 32'h1);
        end
      end
    end
    chk("gap_p_data_lsb", 32'(bus_l.p_data),  32'h6);
    chk("gap_p_valid",    32'(bus_l.p_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure / overrun
    send_word(4'hA, 1'b0);
    chk("bp_first_p_data", 32'(bus_m.p_data), 32'hA);
    send_word(4'h5, 1'b0);
    chk("bp_hold_p_data", 32'(bus_m.p_data),  32'hA);
    chk("bp_overrun",     32'(bus_m.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_overrun_once", 32'(bus_m.overrun), 32'h0);
    chk("bp_still_valid",  32'(bus_m.p_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_drain", 32'(bus_m.p_valid), 32'h0);

    // Simultaneous accept + complete
    send_word(4'h3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sim_held", 32'(bus_m.p_data), 32'h3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sim_p_data",  32'(bus_m.p_data),  32'hC);
    chk("sim_p_valid", 32'(bus_m.p_valid), 32'h1);
    chk("sim_overrun", 32'(bus_m.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Re-frame mid-word
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("reframe_err", 32'(bus_m.frame_err), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("reframe_err_once", 32'(bus_m.frame_err), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("reframe_p_data", 32'(bus_m.p_data), 32'h1);

    // Reset mid-word
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_p_data",  32'(bus_m.p_data),  32'h0);
    chk("clr_p_valid", 32'(bus_m.p_valid), 32'h0);
    chk("clr_busy",    32'(bus_m.busy),    32'h0);
    send_word(4'hF, 1'b1);
    chk("clr_next_word", 32'(bus_m.p_data), 32'hF);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 3) == 0),
           1'($urandom),
           1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
